// File: rtl/bf16_to_int.sv
// Iterative bfloat16 -> int32 converter with a one-bit-per-cycle alignment shifter.
// Define FP2INT_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module bf16_to_int (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] fp_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] int_o,
  output logic        overflow_o,
  output logic        invalid_o,
  output logic        inexact_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [31:0] mag;
  logic        shift_left;
  logic [4:0]  count;
  logic        guard;
  logic        sticky;
  logic        sign;

  logic        sign_in;
  logic [7:0]  exp_in;
  logic [6:0]  frac_in;
  logic [7:0]  exp_off;
  logic [7:0]  left_amt;
  logic [7:0]  right_amt;

  logic        is_special;
  logic [31:0] spec_val;
  logic        spec_ov;
  logic        spec_inv;
  logic        spec_inx;

  logic        round_up;
  logic [31:0] mag_rnd;
  logic [31:0] result;

  assign in_ready_o = (state == IDLE);

  assign sign_in   = fp_i[15];
  assign exp_in    = fp_i[14:7];
  assign frac_in   = fp_i[6:0];
  assign exp_off   = exp_in - 8'd127;
  assign left_amt  = exp_off - 8'd7;
  assign right_amt = 8'd7 - exp_off;

  // Everything that never needs the shifter is settled in the accept cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    is_special = 1'b1;
    spec_val   = 32'h0;
    spec_ov    = 1'b0;
    spec_inv   = 1'b0;
    spec_inx   = 1'b0;
    if (exp_in == 8'd0) begin
      spec_inx = |frac_in;
    end else if (exp_in == 8'hFF) begin
      spec_inv = 1'b1;
      spec_val = (sign_in && frac_in == 7'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (exp_in >= 8'd158) begin
      if (fp_i == 16'hCF00) begin
        spec_val = 32'h8000_0000;
      end else begin
        spec_ov  = 1'b1;
        spec_val = sign_in ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else if (exp_in < 8'd127) begin
      spec_inx = 1'b1;
`ifdef FP2INT_RNE_EN
      // Values in (0.5,1) round to 1; exactly 0.5 ties to the even value 0.
      if (exp_in == 8'd126 && frac_in != 7'd0)
        spec_val = sign_in ? 32'hFFFF_FFFF : 32'h0000_0001;
`endif
    end else begin
      is_special = 1'b0;
    end
  end

`ifdef FP2INT_RNE_EN
  assign round_up = guard & (sticky | mag[0]);
`else
  assign round_up = 1'b0;
`endif

  // Pre-round magnitude is below 2^31, so neither the increment nor the negate can wrap.
  assign mag_rnd = mag + {31'd0, round_up};
  assign result  = sign ? (~mag_rnd + 32'd1) : mag_rnd;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mag         <= 32'h0;
      shift_left  <= 1'b0;
      count       <= 5'd0;
      guard       <= 1'b0;
      sticky      <= 1'b0;
      sign        <= 1'b0;
      int_o       <= 32'h0;
      overflow_o  <= 1'b0;
      invalid_o   <= 1'b0;
      inexact_o   <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            sign <= sign_in;
            if (is_special) begin
              int_o       <= spec_val;
              overflow_o  <= spec_ov;
              invalid_o   <= spec_inv;
              inexact_o   <= spec_inx;
              out_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              mag        <= {24'd0, 1'b1, frac_in};
              shift_left <= (exp_off >= 8'd7);
              count      <= (exp_off >= 8'd7) ? left_amt[4:0] : right_amt[4:0];
              guard      <= 1'b0;
              sticky     <= 1'b0;
              state      <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (count != 5'd0) begin
            if (shift_left) begin
              mag <= mag << 1;
            end else begin
              mag    <= mag >> 1;
              guard  <= mag[0];
              sticky <= sticky | guard;
            end
            count <= count - 5'd1;
          end else begin
            int_o       <= result;
            overflow_o  <= 1'b0;
            invalid_o   <= 1'b0;
            inexact_o   <= guard | sticky;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_to_int.sv
// Directed bench for bf16_to_int: expected results are queued at accept and
// compared when out_valid_o rises; honours FP2INT_RNE_EN like the design.
module tb_bf16_to_int;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] fp_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] int_o;
  logic        overflow_o;
  logic        invalid_o;
  logic        inexact_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] fp;
    logic [31:0] val;
    logic [2:0]  flags;  // {overflow, invalid, inexact}
    int          lat;
  } exp_t;

  exp_t sb[$];

`ifdef FP2INT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  bf16_to_int dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .fp_i        (fp_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .int_o       (int_o),
    .overflow_o  (overflow_o),
    .invalid_o   (invalid_o),
    .inexact_o   (inexact_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Accept one operand, wait for its result, compare against the queued
  // expectation, optionally stall the consumer, then hand the result off.
  task automatic convert(input logic [15:0] fp, input logic [31:0] val,
                         input logic [2:0] flags, input int lat, input int hold);
    exp_t e;
    int   n;
    e = '{fp: fp, val: val, flags: flags, lat: lat};
    sb.push_back(e);
    @(negedge clk_i);
    check($sformatf("%h ready", fp), {31'd0, in_ready_o}, 32'd1);
    fp_i       = fp;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    fp_i       = 16'($urandom);
    check($sformatf("%h busy", fp), {31'd0, in_ready_o}, 32'd0);
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!out_valid_o && n < 40);
    if (sb.size() == 0) begin
      check("scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check($sformatf("%h latency", e.fp), 32'(n), 32'(e.lat));
      check($sformatf("%h valid", e.fp), {31'd0, out_valid_o}, 32'd1);
      check($sformatf("%h int", e.fp), int_o, e.val);
      check($sformatf("%h flags", e.fp), {29'd0, overflow_o, invalid_o, inexact_o}, {29'd0, e.flags});
      repeat (hold) begin
        @(posedge clk_i);
        #1;
        check($sformatf("%h hold int", e.fp), int_o, e.val);
        check($sformatf("%h hold valid", e.fp), {31'd0, out_valid_o}, 32'd1);
      end
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    check($sformatf("%h handoff valid", fp), {31'd0, out_valid_o}, 32'd0);
    check($sformatf("%h handoff ready", fp), {31'd0, in_ready_o}, 32'd1);
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    fp_i        = 16'h0;
    #12;
    check("reset valid", {31'd0, out_valid_o}, 32'd0);
    check("reset ready", {31'd0, in_ready_o}, 32'd1);
    check("reset int", int_o, 32'd0);
    check("reset flags", {29'd0, overflow_o, invalid_o, inexact_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Normal path (k = |E-7|, latency k+1)
    convert(16'h42C8, 32'h0000_0064, 3'b000, 2, 0);                       // 100.0
    convert(16'hC2CB, RNE ? 32'hFFFF_FF9A : 32'hFFFF_FF9B, 3'b001, 2, 0); // -101.5
    convert(16'h4020, 32'h0000_0002, 3'b001, 7, 0);                       // 2.5 tie to even
    convert(16'h3FC0, RNE ? 32'h0000_0002 : 32'h0000_0001, 3'b001, 8, 0); // 1.5
    convert(16'h4040, 32'h0000_0003, 3'b000, 7, 0);                       // 3.0
    convert(16'hC700, 32'hFFFF_8000, 3'b000, 9, 0);                       // -32768
    convert(16'h4B7F, 32'h00FF_0000, 3'b000, 17, 0);

    // Special cases, latency 1
    convert(16'h4F00, 32'h7FFF_FFFF, 3'b100, 1, 0);
    convert(16'hCF00, 32'h8000_0000, 3'b000, 1, 0);
    convert(16'h7FC0, 32'h7FFF_FFFF, 3'b010, 1, 0);
    convert(16'hFF80, 32'h8000_0000, 3'b010, 1, 0);
    convert(16'h7F80, 32'h7FFF_FFFF, 3'b010, 1, 0);
    convert(16'h0000, 32'h0000_0000, 3'b000, 1, 0);
    convert(16'h0001, 32'h0000_0000, 3'b001, 1, 0);
    convert(16'h3F00, 32'h0000_0000, 3'b001, 1, 0);                       // 0.5
    convert(16'h3F40, RNE ? 32'h0000_0001 : 32'h0000_0000, 3'b001, 1, 0); // 0.75
    convert(16'hBF40, RNE ? 32'hFFFF_FFFF : 32'h0000_0000, 3'b001, 1, 0); // -0.75

    // Longest path, then stall the consumer for 5 cycles
    convert(16'h4EFE, 32'h7F00_0000, 3'b000, 24, 5);

    // Abort a conversion mid-shift with reset
    @(negedge clk_i);
    fp_i       = 16'h4EFE;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("abort valid", {31'd0, out_valid_o}, 32'd0);
    check("abort ready", {31'd0, in_ready_o}, 32'd1);
    check("abort int", int_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("abort no result", {31'd0, out_valid_o}, 32'd0);

    convert(16'h42C8, 32'h0000_0064, 3'b000, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
